// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs consecutive FIFO entries into keep-masked wide words
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_W      = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_last,
  output logic                       busy
);

  localparam logic [0:0]       ST_FILL  = 1'b0;
  localparam logic [0:0]       ST_DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);

  logic [0:0]                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             rd_pend_q, rd_pend_d;
  logic                             flush_pend_q, flush_pend_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]  lane_q, lane_d;
  logic                             out_valid_q, out_valid_d;
  logic [DATA_WIDTH*PACK-1:0]       out_data_q, out_data_d;
  logic [PACK-1:0]                  out_keep_q, out_keep_d;
  logic                             out_last_q, out_last_d;

  logic                             out_free;
  logic [CNT_W:0]                   inflight;
  logic                             room;
  logic                             completes_now;
  logic [PACK-1:0]                  part_keep;
  logic [PACK-1:0][DATA_WIDTH-1:0]  part_lanes;

  assign out_free = ~out_valid_q | out_ready;
  assign inflight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pend_q};
  assign room     = inflight < {1'b0, CNT_FULL};

  // A pop may also issue while the last lane is in flight if that word will leave this edge,
  // which keeps the sustained rate at one word every PACK cycles.
  assign completes_now = rd_pend_q & (cnt_q == CNT_LAST) & out_free;

  assign fifo_rd_en = ~rst & ~fifo_empty & ~flush_pend_q & (state_q == ST_FILL)
                    & (room | completes_now);

  always_comb begin
    part_keep  = '0;
    part_lanes = '0;
    for (int i = 0; i < PACK; i++) begin
      part_keep[i]  = CNT_W'(i) < cnt_q;
      part_lanes[i] = part_keep[i] ? lane_q[i] : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    lane_d       = lane_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    rd_pend_d    = fifo_rd_en & ~fifo_empty;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (rd_pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          lane_d[i] = fifo_data;
        end
      end
      if (cnt_q == CNT_LAST) begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = lane_d;
          out_keep_d  = '1;
          out_last_d  = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = CNT_FULL;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_q == CNT_FULL) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = lane_q;
        out_keep_d  = '1;
        out_last_d  = (state_q == ST_DRAIN);
        cnt_d       = '0;
        if (state_q == ST_DRAIN) begin
          state_d      = ST_FILL;
          flush_pend_d = 1'b0;
        end
      end
    end else if (state_q == ST_DRAIN && out_free) begin
      if (cnt_q != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = part_lanes;
        out_keep_d  = part_keep;
        out_last_d  = 1'b1;
        cnt_d       = '0;
      end
      state_d      = ST_FILL;
      flush_pend_d = 1'b0;
    end

    if (state_q == ST_FILL && flush && !flush_pend_q) begin
      flush_pend_d = 1'b1;
      state_d      = ST_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      lane_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      lane_q       <= lane_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign busy      = ~rst & ((cnt_q != '0) | rd_pend_q | out_valid_q | flush_pend_q);

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer with a registered-output FIFO
module tb_fifo_word_packer;
  localparam int DW = 8;
  localparam int PK = 4;
  localparam int W  = DW * PK;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [PK-1:0] out_keep;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int failures = 0;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte FIFO with registered data_out, reset by the same rst
  logic [DW-1:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= 0;
      fifo_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Collect accepted words and pops
  logic [W-1:0]  got_data [$];
  logic [PK-1:0] got_keep [$];
  logic          got_last [$];
  int            got_cyc  [$];
  int cyc = 0;
  int rd_pulses = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (fifo_rd_en && !fifo_empty) rd_pulses = rd_pulses + 1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_keep.push_back(out_keep);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Reference model: bytes are grouped PK at a time; a flush emits the remainder
  logic [DW-1:0] mdl_pend [$];
  logic [W-1:0]  exp_data [$];
  logic [PK-1:0] exp_keep [$];
  logic          exp_last [$];

  task automatic model_emit(input logic last);
    logic [W-1:0]  w;
    logic [PK-1:0] k;
    w = '0;
    k = '0;
    for (int i = 0; i < mdl_pend.size(); i++) begin
      w[i*DW +: DW] = mdl_pend[i];
      k[i] = 1'b1;
    end
    exp_data.push_back(w);
    exp_keep.push_back(k);
    exp_last.push_back(last);
    mdl_pend.delete();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fmem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
    mdl_pend.push_back(b);
    if (mdl_pend.size() == PK) model_emit(1'b0);
  endtask

  task automatic model_flush();
    if (mdl_pend.size() > 0) model_emit(1'b1);
  endtask

  task automatic clear_all();
    got_data.delete(); got_keep.delete(); got_last.delete(); got_cyc.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); mdl_pend.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    #1 rst = 1'b1;
    wr_ptr = 0;
    tick();
    checks += 6;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    if (out_keep !== '0) begin failures++; $display("FAIL reset_keep got=%b exp=0", out_keep); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL idle_empty bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_single_word();
    int p0;
    clear_all();
    out_ready = 1'b1;
    p0 = rd_pulses;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    for (int k = 0; k < 40 && got_data.size() < 1; k++) tick();
    repeat (10) tick();
    checks += 5;
    if (got_data.size() !== 1) begin
      failures++; $display("FAIL single_count got=%0d exp=1", got_data.size());
    end else begin
      if (got_data[0] !== 32'h44332211) begin failures++; $display("FAIL single_data got=%h exp=44332211", got_data[0]); end
      if (got_keep[0] !== 4'b1111) begin failures++; $display("FAIL single_keep got=%b exp=1111", got_keep[0]); end
      if (got_last[0] !== 1'b0) begin failures++; $display("FAIL single_last got=%b exp=0", got_last[0]); end
    end
    if (rd_pulses - p0 !== 4) begin failures++; $display("FAIL single_pops got=%0d exp=4", rd_pulses - p0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stream16();
    logic [W-1:0] w;
    clear_all();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(DW'(i));
    for (int k = 0; k < 100 && got_data.size() < 4; k++) tick();
    repeat (10) tick();
    checks++;
    if (got_data.size() !== 4) begin
      failures++; $display("FAIL stream_count got=%0d exp=4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        w = '0;
        for (int j = 0; j < PK; j++) w[j*DW +: DW] = DW'(4 * i + j);
        checks++;
        if (got_data[i] !== w || got_keep[i] !== 4'hF || got_last[i] !== 1'b0) begin
          failures++;
          $display("FAIL stream_word%0d got=%h/%b/%b exp=%h/1111/0", i, got_data[i], got_keep[i], got_last[i], w);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] !== 4) begin
          failures++; $display("FAIL stream_gap%0d got=%0d exp=4", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [W-1:0] w;
    clear_all();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'h40 + DW'(i));
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k >= 8 && (out_valid !== 1'b1 || out_data !== 32'h43424140)) bad++;
    end
    checks += 5;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    if (out_keep !== 4'hF) begin failures++; $display("FAIL hold_keep got=%b exp=1111", out_keep); end
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL hold_rd_en got=%b exp=0", fifo_rd_en); end
    if (wr_ptr - rd_ptr !== 4) begin failures++; $display("FAIL hold_fifo_level got=%0d exp=4", wr_ptr - rd_ptr); end
    if (got_data.size() !== 0) begin failures++; $display("FAIL hold_leak got=%0d exp=0", got_data.size()); end
    out_ready = 1'b1;
    for (int k = 0; k < 60 && got_data.size() < 3; k++) tick();
    repeat (8) tick();
    checks++;
    if (got_data.size() !== 3) begin
      failures++; $display("FAIL release_count got=%0d exp=3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        w = '0;
        for (int j = 0; j < PK; j++) w[j*DW +: DW] = 8'h40 + DW'(4 * i + j);
        checks++;
        if (got_data[i] !== w || got_keep[i] !== 4'hF || got_last[i] !== 1'b0) begin
          failures++;
          $display("FAIL release_word%0d got=%h/%b/%b exp=%h/1111/0", i, got_data[i], got_keep[i], got_last[i], w);
        end
      end
    end
  endtask

  task automatic test_flush();
    clear_all();
    out_ready = 1'b1;
    push_byte(8'hA1); push_byte(8'hA2);
    repeat (6) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 0; k < 20 && got_data.size() < 1; k++) tick();
    repeat (3) tick();
    checks += 2;
    if (got_data.size() !== 1) begin
      failures++; $display("FAIL flush_count got=%0d exp=1", got_data.size());
    end else if (got_data[0] !== 32'h0000A2A1 || got_keep[0] !== 4'b0011 || got_last[0] !== 1'b1) begin
      failures++;
      $display("FAIL flush_word got=%h/%b/%b exp=0000a2a1/0011/1", got_data[0], got_keep[0], got_last[0]);
    end
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    clear_all();
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (10) tick();
    checks += 2;
    if (got_data.size() !== 0) begin failures++; $display("FAIL empty_flush_count got=%0d exp=0", got_data.size()); end
    if (busy !== 1'b0) begin failures++; $display("FAIL empty_flush_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_byte(8'h50 + DW'(i));
    repeat (15) tick();
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", out_valid); end
    if (wr_ptr - rd_ptr !== 0) begin failures++; $display("FAIL pre_rst_fifo got=%0d exp=0", wr_ptr - rd_ptr); end
    rst = 1'b1;
    wr_ptr = 0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    if (out_keep !== '0) begin failures++; $display("FAIL mid_rst_keep got=%b exp=0", out_keep); end
    if (out_data !== '0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", out_data); end
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rst_rd_en got=%b exp=0", fifo_rd_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    tick();
    clear_all();
    out_ready = 1'b1;
    push_byte(8'h60); push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    for (int k = 0; k < 30 && got_data.size() < 1; k++) tick();
    repeat (4) tick();
    checks++;
    if (got_data.size() !== 1) begin
      failures++; $display("FAIL post_rst_count got=%0d exp=1", got_data.size());
    end else if (got_data[0] !== 32'h63626160 || got_keep[0] !== 4'hF || got_last[0] !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_word got=%h/%b/%b exp=63626160/1111/0", got_data[0], got_keep[0], got_last[0]);
    end
  endtask

  task automatic test_random();
    int n;
    int pushed;
    for (int r = 0; r < 4; r++) begin
      clear_all();
      n = $urandom_range(30, 1);
      pushed = 0;
      for (int k = 0; k < 500 && pushed < n; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          push_byte(DW'($urandom));
          pushed++;
        end
        out_ready = ($urandom_range(3, 0) != 0);
        tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 100 && !fifo_empty; k++) tick();
      repeat (8) tick();
      flush = 1'b1; tick(); flush = 1'b0;
      model_flush();
      repeat (12) tick();
      checks++;
      if (got_data.size() !== exp_data.size()) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] || got_last[i] !== exp_last[i]) begin
            failures++;
            $display("FAIL rand%0d_word%0d got=%h/%b/%b exp=%h/%b/%b", r, i,
                     got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream16();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
